// File: rtl/useq_next_addr_ctrl.sv
// Next-address control for cascaded Am2909 slices: opcode decode, condition select,
// loop counter, stack-depth shadow with sticky overflow/underflow flags.
module useq_next_addr_ctrl #(
    parameter int CTR_W = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [3:0]       instr,
    input  logic [2:0]       cond_sel,
    input  logic             cond_pol,
    input  logic [7:0]       cond_in,
    input  logic [CTR_W-1:0] data_in,
    input  logic             err_clr,
    output logic             s1,
    output logic             s0,
    output logic             zero_n,
    output logic             fe_n,
    output logic             pup,
    output logic             cin,
    output logic             re_n,
    output logic             pl_oe_n,
    output logic             map_oe_n,
    output logic             vect_oe_n,
    output logic             ctr_zero,
    output logic [2:0]       depth,
    output logic             stk_ovf,
    output logic             stk_unf
);

    localparam logic [2:0] DEPTH_MAX = 3'(DEPTH);

    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic [2:0]       depth_q, depth_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;

    logic       pass, ctr_nz;
    logic [1:0] sel;
    logic       zn, fen, pu, ci, ren, pl_n, map_n, vect_n;
    logic       do_clr, do_load, do_dec, do_push, do_pop;
    logic       ovf_set, unf_set;

    assign pass   = (cond_sel == 3'd0) | (cond_in[cond_sel] ^ cond_pol);
    assign ctr_nz = (ctr_q != '0);

    always_comb begin
        sel     = 2'b00;
        zn      = 1'b1;
        fen     = 1'b1;
        pu      = 1'b0;
        ci      = 1'b1;
        ren     = 1'b1;
        pl_n    = 1'b0;
        map_n   = 1'b1;
        vect_n  = 1'b1;
        do_clr  = 1'b0;
        do_load = 1'b0;
        do_dec  = 1'b0;
        case (instr)
            4'h0: begin zn = 1'b0; ci = 1'b0; do_clr = 1'b1; end
            4'h1: if (pass) begin sel = 2'b11; fen = 1'b0; pu = 1'b1; end
            4'h2: begin sel = 2'b11; map_n = 1'b0; pl_n = 1'b1; end
            4'h3: if (pass) sel = 2'b11;
            4'h4: begin fen = 1'b0; pu = 1'b1; do_load = pass; end
            4'h5: begin fen = 1'b0; pu = 1'b1; sel = pass ? 2'b11 : 2'b01; end
            4'h6: begin vect_n = 1'b0; pl_n = 1'b1; if (pass) sel = 2'b11; end
            4'h7: sel = pass ? 2'b11 : 2'b01;
            4'h8: if (ctr_nz) begin sel = 2'b10; do_dec = 1'b1; end else fen = 1'b0;
            4'h9: if (ctr_nz) begin sel = 2'b11; do_dec = 1'b1; end
            4'hA: if (pass) begin sel = 2'b10; fen = 1'b0; end
            4'hB: if (pass) begin sel = 2'b11; fen = 1'b0; end
            4'hC: begin do_load = 1'b1; ren = 1'b0; end
            4'hD: if (pass) fen = 1'b0; else sel = 2'b10;
            4'hE: sel = 2'b00;
            4'hF: begin
                if (pass) fen = 1'b0;
                else if (ctr_nz) begin sel = 2'b10; do_dec = 1'b1; end
                else begin sel = 2'b11; fen = 1'b0; end
            end
            default: sel = 2'b00;
        endcase
    end

    assign do_push = ~fen & pu;
    assign do_pop  = ~fen & ~pu;

    // Holding reset forces Y=0 so the slices clock PC<=0 with no stack or AR activity.
    assign s1        = reset_n & sel[1];
    assign s0        = reset_n & sel[0];
    assign zero_n    = reset_n & zn;
    assign cin       = reset_n & ci;
    assign fe_n      = ~reset_n | fen;
    assign pup       = reset_n & pu;
    assign re_n      = ~reset_n | ren;
    assign pl_oe_n   = reset_n & pl_n;
    assign map_oe_n  = ~reset_n | map_n;
    assign vect_oe_n = ~reset_n | vect_n;

    always_comb begin
        ctr_d   = ctr_q;
        depth_d = depth_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (do_load)
            ctr_d = data_in;
        else if (do_dec)
            ctr_d = ctr_q - CTR_W'(1);
        if (do_clr) begin
            depth_d = 3'd0;
        end else if (do_push) begin
            if (depth_q == DEPTH_MAX) ovf_set = 1'b1;
            else                      depth_d = depth_q + 3'd1;
        end else if (do_pop) begin
            if (depth_q == 3'd0) unf_set = 1'b1;
            else                 depth_d = depth_q - 3'd1;
        end
        ovf_d = ovf_set | (ovf_q & ~err_clr);
        unf_d = unf_set | (unf_q & ~err_clr);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctr_q   <= '0;
            depth_q <= 3'd0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            ctr_q   <= ctr_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign ctr_zero = ~ctr_nz;
    assign depth    = depth_q;
    assign stk_ovf  = ovf_q;
    assign stk_unf  = unf_q;

endmodule

// File: tb/tb_useq_next_addr_ctrl.sv
// Bench for useq_next_addr_ctrl: directed sequences plus random opcodes against an
// opcode-table reference model of the sequencing rules.
module tb_useq_next_addr_ctrl;
    localparam int CTR_W = 8;
    localparam int DEPTH = 4;

    localparam int STK_NONE = 0, STK_PUSH = 1, STK_POP = 2, STK_CLR = 3;
    localparam int C_HOLD = 0, C_LOAD = 1, C_DEC = 2;

    logic             clock = 1'b0;
    logic             reset_n = 1'b1;
    logic [3:0]       instr = 4'hE;
    logic [2:0]       cond_sel = 3'd0;
    logic             cond_pol = 1'b0;
    logic [7:0]       cond_in = 8'h00;
    logic [CTR_W-1:0] data_in = '0;
    logic             err_clr = 1'b0;
    logic s1, s0, zero_n, fe_n, pup, cin, re_n, pl_oe_n, map_oe_n, vect_oe_n;
    logic ctr_zero, stk_ovf, stk_unf;
    logic [2:0] depth;

    int n_chk = 0;
    int n_fail = 0;
    int m_ctr = 0;
    int m_depth = 0;
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    typedef struct {
        logic [1:0] s;
        logic       zero_n, fe_n, pup, cin, re_n;
        logic [2:0] oe_n;
        int         stk;
        int         cact;
    } exp_t;

    useq_next_addr_ctrl #(.CTR_W(CTR_W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .instr(instr), .cond_sel(cond_sel),
        .cond_pol(cond_pol), .cond_in(cond_in), .data_in(data_in), .err_clr(err_clr),
        .s1(s1), .s0(s0), .zero_n(zero_n), .fe_n(fe_n), .pup(pup), .cin(cin),
        .re_n(re_n), .pl_oe_n(pl_oe_n), .map_oe_n(map_oe_n), .vect_oe_n(vect_oe_n),
        .ctr_zero(ctr_zero), .depth(depth), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Sequencer rules: pick the Y source, stack action, counter action and D-bus source.
    function automatic exp_t model(input logic [3:0] op, input bit p, input int ctr);
        exp_t e;
        int   dsrc;
        e.s = 2'd0; e.zero_n = 1'b1; e.cin = 1'b1; e.re_n = 1'b1;
        e.stk = STK_NONE; e.cact = C_HOLD; dsrc = 0;
        case (op)
            4'h0: begin e.zero_n = 1'b0; e.cin = 1'b0; e.stk = STK_CLR; end
            4'h1: if (p) begin e.s = 2'd3; e.stk = STK_PUSH; end
            4'h2: begin e.s = 2'd3; dsrc = 1; end
            4'h3: e.s = p ? 2'd3 : 2'd0;
            4'h4: begin e.stk = STK_PUSH; if (p) e.cact = C_LOAD; end
            4'h5: begin e.stk = STK_PUSH; e.s = p ? 2'd3 : 2'd1; end
            4'h6: begin dsrc = 2; e.s = p ? 2'd3 : 2'd0; end
            4'h7: e.s = p ? 2'd3 : 2'd1;
            4'h8: if (ctr != 0) begin e.s = 2'd2; e.cact = C_DEC; end else e.stk = STK_POP;
            4'h9: if (ctr != 0) begin e.s = 2'd3; e.cact = C_DEC; end
            4'hA: if (p) begin e.s = 2'd2; e.stk = STK_POP; end
            4'hB: if (p) begin e.s = 2'd3; e.stk = STK_POP; end
            4'hC: begin e.cact = C_LOAD; e.re_n = 1'b0; end
            4'hD: if (p) e.stk = STK_POP; else e.s = 2'd2;
            4'hF: if (p) e.stk = STK_POP;
                  else if (ctr != 0) begin e.s = 2'd2; e.cact = C_DEC; end
                  else begin e.s = 2'd3; e.stk = STK_POP; end
            default: e.s = 2'd0;
        endcase
        e.fe_n = !(e.stk == STK_PUSH || e.stk == STK_POP);
        e.pup  = (e.stk == STK_PUSH);
        e.oe_n = ~(3'b100 >> dsrc);
        return e;
    endfunction

    task automatic model_edge(input exp_t e, input int d, input bit ec);
        bit so, su;
        so = 1'b0; su = 1'b0;
        if (e.cact == C_LOAD) m_ctr = d;
        else if (e.cact == C_DEC && m_ctr > 0) m_ctr = m_ctr - 1;
        case (e.stk)
            STK_CLR:  m_depth = 0;
            STK_PUSH: if (m_depth == DEPTH) so = 1'b1; else m_depth = m_depth + 1;
            STK_POP:  if (m_depth == 0) su = 1'b1; else m_depth = m_depth - 1;
            default:  ;
        endcase
        m_ovf = so || (m_ovf && !ec);
        m_unf = su || (m_unf && !ec);
    endtask

    task automatic model_reset();
        m_ctr = 0; m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".ctr_zero"}, 32'(ctr_zero), 32'(m_ctr == 0));
        chk({tag, ".depth"},    32'(depth),    32'(m_depth));
        chk({tag, ".ovf"},      32'(stk_ovf),  32'(m_ovf));
        chk({tag, ".unf"},      32'(stk_unf),  32'(m_unf));
    endtask

    task automatic chk_forced(input string tag);
        chk({tag, ".s"},      32'({s1, s0}), 32'd0);
        chk({tag, ".zero_n"}, 32'(zero_n), 32'd0);
        chk({tag, ".cin"},    32'(cin), 32'd0);
        chk({tag, ".fe_n"},   32'(fe_n), 32'd1);
        chk({tag, ".re_n"},   32'(re_n), 32'd1);
        chk({tag, ".oe"},     32'({pl_oe_n, map_oe_n, vect_oe_n}), 32'b011);
    endtask

    // Called at posedge+1: drive, check controls mid-cycle, clock, check state.
    task automatic step(input string tag, input logic [3:0] op, input logic [2:0] sel,
                        input bit pol, input logic [7:0] cv, input int d, input bit ec);
        exp_t e;
        bit   p;
        instr = op; cond_sel = sel; cond_pol = pol; cond_in = cv;
        data_in = CTR_W'(d); err_clr = ec;
        #4;
        p = (sel == 3'd0) || (cv[sel] != pol);
        e = model(op, p, m_ctr);
        chk({tag, ".s"},      32'({s1, s0}), 32'(e.s));
        chk({tag, ".zero_n"}, 32'(zero_n), 32'(e.zero_n));
        chk({tag, ".cin"},    32'(cin), 32'(e.cin));
        chk({tag, ".fe_n"},   32'(fe_n), 32'(e.fe_n));
        chk({tag, ".pup"},    32'(pup), 32'(e.pup));
        chk({tag, ".re_n"},   32'(re_n), 32'(e.re_n));
        chk({tag, ".oe"},     32'({pl_oe_n, map_oe_n, vect_oe_n}), 32'(e.oe_n));
        @(posedge clock);
        #1;
        model_edge(e, d, ec);
        chk_state(tag);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #1;
        chk_forced("rst");
        chk_state("rst");
        chk("rst.ctr_zero_const", 32'(ctr_zero), 32'd1);
        @(posedge clock);
        #1 reset_n = 1'b1;

        step("t1_cont", 4'hE, 3'd0, 1'b0, 8'h00, 0, 1'b0);
        chk("t1.cin", 32'(cin), 32'd1);

        step("t2_cjs_p", 4'h1, 3'd2, 1'b0, 8'h04, 0, 1'b0);
        chk("t2.depth1", 32'(depth), 32'd1);
        step("t2_cjs_f", 4'h1, 3'd2, 1'b1, 8'h04, 0, 1'b0);
        chk("t2.depth_hold", 32'(depth), 32'd1);

        step("t3_ldct", 4'hC, 3'd0, 1'b0, 8'h00, 3, 1'b0);
        for (int i = 0; i < 4; i++) step("t3_rpct", 4'h9, 3'd0, 1'b0, 8'h00, 0, 1'b0);
        chk("t3.ctr_zero", 32'(ctr_zero), 32'd1);

        step("t4_jz", 4'h0, 3'd0, 1'b0, 8'h00, 0, 1'b0);
        for (int i = 0; i < 5; i++) step("t4_push", 4'h4, 3'd0, 1'b0, 8'h00, 0, 1'b0);
        chk("t4.depth4", 32'(depth), 32'd4);
        chk("t4.ovf_set", 32'(stk_ovf), 32'd1);
        step("t4_clr", 4'hE, 3'd0, 1'b0, 8'h00, 0, 1'b1);
        chk("t4.ovf_clr", 32'(stk_ovf), 32'd0);
        // Set and clear in the same cycle: set must win.
        step("t4_setclr", 4'h1, 3'd0, 1'b0, 8'h00, 0, 1'b1);
        chk("t4.ovf_setwins", 32'(stk_ovf), 32'd1);

        step("t5_jz", 4'h0, 3'd0, 1'b0, 8'h00, 0, 1'b1);
        step("t5_crtn", 4'hA, 3'd0, 1'b0, 8'h00, 0, 1'b0);
        chk("t5.unf", 32'(stk_unf), 32'd1);
        chk("t5.depth0", 32'(depth), 32'd0);

        step("t6_push", 4'h1, 3'd0, 1'b0, 8'h00, 0, 1'b1);
        step("t6_push", 4'h1, 3'd0, 1'b0, 8'h00, 0, 1'b0);
        step("t6_ldct", 4'hC, 3'd0, 1'b0, 8'h00, 2, 1'b0);
        step("t6_twb_f", 4'hF, 3'd1, 1'b0, 8'h00, 0, 1'b0);
        step("t6_twb_p", 4'hF, 3'd1, 1'b0, 8'h02, 0, 1'b0);
        step("t6_ldct0", 4'hC, 3'd0, 1'b0, 8'h00, 0, 1'b0);
        step("t6_twb_f0", 4'hF, 3'd1, 1'b0, 8'h00, 0, 1'b0);
        chk("t6.depth", 32'(depth), 32'd0);

        step("t7_push", 4'h1, 3'd0, 1'b0, 8'h00, 0, 1'b0);
        step("t7_ldct", 4'hC, 3'd0, 1'b0, 8'h00, 5, 1'b0);
        instr = 4'hF; cond_sel = 3'd1; cond_pol = 1'b0; cond_in = 8'h00;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk_forced("t7_midrst");
        chk_state("t7_midrst");
        @(posedge clock);
        #1;
        chk_state("t7_held");
        reset_n = 1'b1;

        for (int i = 0; i < 800; i++) begin
            int d;
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 4));
            step("rnd", 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), d,
                 $urandom_range(0, 5) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
